result_bram_writer: RTL

//  Writes systolic accumulator results into a BRAM so the PS can read them over an AXI BRAM

---
 rtl/result_bram_writer_pkg.sv | 23 ++
 rtl/result_bram_writer_if.sv | 39 +++
 rtl/result_lane_capture.sv | 47 ++++
 rtl/result_bram_writer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/result_bram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_bram_writer_pkg
// Brief    : Shared types and constants for the result BRAM writer.
// Revision : 1.0 - initial release
// ============================================================================
package result_bram_writer_pkg;

   localparam logic [15:0] STATUS_MAGIC   = 16'hA5C3;
   localparam int          STATUS_MAGIC_W = 16;
   localparam int          STATUS_OVF_BIT = 16;
   localparam int          STATUS_CNT_W   = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_WRITE   = 3'd2,
      S_STATUS  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/result_bram_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : result_bram_writer_if
// Brief    : Control, lane-result and BRAM-port bundle of the result writer.
// Revision : 1.0 - initial release
// ============================================================================
interface result_bram_writer_if #(
   parameter int N_MACS = 4,
   parameter int ACC_W  = 16,
   parameter int ADDR_W = 9
) ();
   localparam int DW = N_MACS * ACC_W;

   logic                start;
   logic                clear_all;
   logic [DW-1:0]       acc_in;
   logic [N_MACS-1:0]   valid_in;
   logic                bram_en;
   logic [DW/8-1:0]     bram_we;
   logic [ADDR_W-1:0]   bram_addr;
   logic [DW-1:0]       bram_din;
   logic                busy;
   logic                done;
   logic                overflow;
   logic [ADDR_W-1:0]   rows_written;

   modport slave (
      input  start, clear_all, acc_in, valid_in,
      output bram_en, bram_we, bram_addr, bram_din,
      output busy, done, overflow, rows_written
   );

   modport master (
      output start, clear_all, acc_in, valid_in,
      input  bram_en, bram_we, bram_addr, bram_din,
      input  busy, done, overflow, rows_written
   );
endinterface
`default_nettype wire

// File: rtl/result_lane_capture.sv
`default_nettype none
// ============================================================================
// Module   : result_lane_capture
// Brief    : One lane's result register, pending flag and overflow detect.
// Revision : 1.0 - initial release
// ============================================================================
module result_lane_capture #(
   parameter int ACC_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             clear,
   input  wire logic             collect,
   input  wire logic             write,
   input  wire logic             valid,
   input  wire logic [ACC_W-1:0] din,
   output logic      [ACC_W-1:0] dout,
   output logic                  pending,
   output logic                  ovf_hit
);

   assign ovf_hit = collect & valid & pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout    <= '0;
         pending <= 1'b0;
      end else if (clear) begin
         pending <= 1'b0;
      end else if (collect) begin
         if (valid && !pending) begin
            dout    <= din;
            pending <= 1'b1;
         end
      end else if (write) begin
         // A strobe during the write cycle belongs to the next row.
         if (valid) begin
            dout    <= din;
            pending <= 1'b1;
         end else begin
            pending <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/result_bram_writer.sv
`default_nettype none
// ============================================================================
// Module   : result_bram_writer
// Brief    : Packs per-lane accumulator results into BRAM rows, then a status word.
// Revision : 1.0 - initial release
// ============================================================================
module result_bram_writer
   import result_bram_writer_pkg::*;
#(
   parameter int N_MACS      = 4,
   parameter int ACC_W       = 16,
   parameter int ADDR_W      = 9,
   parameter int NUM_ROWS    = 4,
   parameter int BASE_ADDR   = 0,
   parameter int STATUS_ADDR = 511
) (
   input  wire logic             clk,
   input  wire logic             rst,
   result_bram_writer_if.slave   bus
);

   localparam int DW = N_MACS * ACC_W;
   localparam logic [ADDR_W-1:0] C_NUM_ROWS    = ADDR_W'(NUM_ROWS);
   localparam logic [ADDR_W-1:0] C_BASE_ADDR   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] C_STATUS_ADDR = ADDR_W'(STATUS_ADDR);

   state_t              r_state;
   logic [DW-1:0]       w_row;
   logic [N_MACS-1:0]   w_pending;
   logic [N_MACS-1:0]   w_ovf_hit;
   logic [DW-1:0]       w_status;
   logic [ADDR_W-1:0]   w_rows_next;
   logic                w_idle_like;
   logic                w_clear;
   logic                w_collect;
   logic                w_write;

   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_clear     = bus.clear_all || (bus.start && w_idle_like);
   assign w_collect   = (r_state == S_COLLECT);
   assign w_write     = (r_state == S_WRITE);
   assign w_rows_next = bus.rows_written + 1'b1;

   for (genvar i = 0; i < N_MACS; i++) begin : g_lanes
      result_lane_capture #(
         .ACC_W (ACC_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .clear   (w_clear),
         .collect (w_collect),
         .write   (w_write),
         .valid   (bus.valid_in[i]),
         .din     (bus.acc_in[i*ACC_W +: ACC_W]),
         .dout    (w_row[i*ACC_W +: ACC_W]),
         .pending (w_pending[i]),
         .ovf_hit (w_ovf_hit[i])
      );
   end

   // Status word carries the count as it will stand after the final row commits.
   always_comb begin
      w_status = '0;
      w_status[DW-1 -: STATUS_MAGIC_W]  = STATUS_MAGIC;
      w_status[STATUS_OVF_BIT]          = bus.overflow;
      w_status[STATUS_CNT_W-1:0]        = STATUS_CNT_W'(w_rows_next);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         bus.bram_en      <= 1'b0;
         bus.bram_we      <= '0;
         bus.bram_addr    <= '0;
         bus.bram_din     <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.overflow     <= 1'b0;
         bus.rows_written <= '0;
      end else if (bus.clear_all) begin
         r_state          <= S_IDLE;
         bus.bram_en      <= 1'b0;
         bus.bram_we      <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.overflow     <= 1'b0;
         bus.rows_written <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_state          <= S_COLLECT;
                  bus.busy         <= 1'b1;
                  bus.done         <= 1'b0;
                  bus.overflow     <= 1'b0;
                  bus.rows_written <= '0;
               end
            end
            S_COLLECT: begin
               if (|w_ovf_hit) begin
                  bus.overflow <= 1'b1;
               end
               if (&w_pending) begin
                  r_state       <= S_WRITE;
                  bus.bram_en   <= 1'b1;
                  bus.bram_we   <= '1;
                  bus.bram_addr <= C_BASE_ADDR + bus.rows_written;
                  bus.bram_din  <= w_row;
               end
            end
            S_WRITE: begin
               bus.rows_written <= w_rows_next;
               if (w_rows_next == C_NUM_ROWS) begin
                  r_state       <= S_STATUS;
                  bus.bram_addr <= C_STATUS_ADDR;
                  bus.bram_din  <= w_status;
               end else begin
                  r_state     <= S_COLLECT;
                  bus.bram_en <= 1'b0;
                  bus.bram_we <= '0;
               end
            end
            S_STATUS: begin
               r_state     <= S_DONE;
               bus.bram_en <= 1'b0;
               bus.bram_we <= '0;
               bus.busy    <= 1'b0;
               bus.done    <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
